// File: rtl/multi_channel_timer.sv
// multi_channel_timer: CHANNELS independent WIDTH-bit counters, each with a
// period and mode latched on start, periodic or one-shot operation,
// enable/pause, synchronous clear, a one-cycle terminal-count pulse and
// busy/done status. any_tc_out is the registered OR of all channel events.
module multi_channel_timer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [CHANNELS-1:0]       start_in,
    input  logic [CHANNELS-1:0]       clear_in,
    input  logic [CHANNELS-1:0]       en_in,
    input  logic [CHANNELS-1:0]       mode_in,
    input  logic [CHANNELS*WIDTH-1:0] period_in,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       tc_out,
    output logic [CHANNELS-1:0]       busy_out,
    output logic [CHANNELS-1:0]       done_out,
    output logic                      any_tc_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]          state_r      [CHANNELS];
    logic [1:0]          state_nxt_s  [CHANNELS];
    logic [WIDTH-1:0]    count_r      [CHANNELS];
    logic [WIDTH-1:0]    count_nxt_s  [CHANNELS];
    logic [WIDTH-1:0]    period_r     [CHANNELS];
    logic [WIDTH-1:0]    period_nxt_s [CHANNELS];
    logic [WIDTH-1:0]    term_s       [CHANNELS];
    logic [CHANNELS-1:0] mode_r;
    logic [CHANNELS-1:0] mode_nxt_s;
    logic [CHANNELS-1:0] tc_r;
    logic [CHANNELS-1:0] tc_nxt_s;
    logic                any_tc_r;

    // State register: per-channel FSM state, count, latched settings and tc flags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]  <= ST_IDLE;
                count_r[i]  <= ZERO_W;
                period_r[i] <= ZERO_W;
            end
            mode_r   <= {CHANNELS{1'b0}};
            tc_r     <= {CHANNELS{1'b0}};
            any_tc_r <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]  <= state_nxt_s[i];
                count_r[i]  <= count_nxt_s[i];
                period_r[i] <= period_nxt_s[i];
            end
            mode_r   <= mode_nxt_s;
            tc_r     <= tc_nxt_s;
            any_tc_r <= |tc_nxt_s;
        end
    end

    // Next-state logic per channel with priority clear > start > count.
    always_comb begin
        mode_nxt_s = mode_r;
        tc_nxt_s   = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            // Wraps modulo 2^WIDTH, so period 0 yields a full-range count.
            term_s[i]       = period_r[i] - ONE_W;
            state_nxt_s[i]  = state_r[i];
            count_nxt_s[i]  = count_r[i];
            period_nxt_s[i] = period_r[i];
            if (clear_in[i]) begin
                state_nxt_s[i] = ST_IDLE;
                count_nxt_s[i] = ZERO_W;
            end else if (start_in[i]) begin
                state_nxt_s[i]  = ST_RUN;
                count_nxt_s[i]  = ZERO_W;
                period_nxt_s[i] = period_in[i*WIDTH +: WIDTH];
                mode_nxt_s[i]   = mode_in[i];
            end else begin
                case (state_r[i])
                    ST_RUN: begin
                        if (en_in[i]) begin
                            if (count_r[i] == term_s[i]) begin
                                tc_nxt_s[i] = 1'b1;
                                if (mode_r[i]) begin
                                    // One-shot: hold at terminal value and finish.
                                    state_nxt_s[i] = ST_DONE;
                                end else begin
                                    count_nxt_s[i] = ZERO_W;
                                end
                            end else begin
                                count_nxt_s[i] = count_r[i] + ONE_W;
                            end
                        end else begin
                            count_nxt_s[i] = count_r[i];
                        end
                    end
                    ST_IDLE: state_nxt_s[i] = ST_IDLE;
                    ST_DONE: state_nxt_s[i] = ST_DONE;
                    default: begin
                        state_nxt_s[i] = ST_IDLE;
                        count_nxt_s[i] = ZERO_W;
                    end
                endcase
            end
        end
    end

    // Output decode: status bits come straight from the registered state.
    always_comb begin
        count_out = {(CHANNELS*WIDTH){1'b0}};
        busy_out  = {CHANNELS{1'b0}};
        done_out  = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            count_out[i*WIDTH +: WIDTH] = count_r[i];
            busy_out[i] = (state_r[i] == ST_RUN);
            done_out[i] = (state_r[i] == ST_DONE);
        end
        tc_out     = tc_r;
        any_tc_out = any_tc_r;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed testbench for multi_channel_timer: a vector table for the periodic
// and one-shot basics, then hand-written sequences for pause, edge periods,
// clear/start priority, restart during RUN and asynchronous reset.
module tb_multi_channel_timer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   start, clear, en, mode;
    logic [127:0] period;
    logic [127:0] count;
    logic [3:0]   tc, busy, done;
    logic         any_tc;

    // Narrow single-channel instance for the full-range (period 0) check.
    logic         start4, clear4, en4, mode4;
    logic [3:0]   period4, count4;
    logic         tc4, busy4, done4, any_tc4;

    int errors = 0;
    int checks = 0;

    multi_channel_timer #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .clear_in(clear),
        .en_in(en), .mode_in(mode), .period_in(period), .count_out(count),
        .tc_out(tc), .busy_out(busy), .done_out(done), .any_tc_out(any_tc)
    );

    multi_channel_timer #(.WIDTH(4), .CHANNELS(1)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start4), .clear_in(clear4),
        .en_in(en4), .mode_in(mode4), .period_in(period4), .count_out(count4),
        .tc_out(tc4), .busy_out(busy4), .done_out(done4), .any_tc_out(any_tc4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  start, clear, en, mode;
        logic [31:0] p0, p1;
        logic [31:0] c0, c1;
        logic [3:0]  tc, busy, done;
        logic        any;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle to a point away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return count[ch*32 +: 32];
    endfunction

    initial begin
        int m0;
        // ch0 periodic period 4, ch1 one-shot period 3, then ch1 restart.
        tbl[0]  = '{4'b0011, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd0, 32'd0, 4'b0000, 4'b0011, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd1, 32'd1, 4'b0000, 4'b0011, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd2, 32'd2, 4'b0000, 4'b0011, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd3, 32'd2, 4'b0010, 4'b0001, 4'b0010, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd0, 32'd2, 4'b0001, 4'b0001, 4'b0010, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd1, 32'd2, 4'b0000, 4'b0001, 4'b0010, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd2, 32'd2, 4'b0000, 4'b0001, 4'b0010, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd3, 32'd2, 4'b0000, 4'b0001, 4'b0010, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd0, 32'd2, 4'b0001, 4'b0001, 4'b0010, 1'b1};
        tbl[9]  = '{4'b0010, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd1, 32'd0, 4'b0000, 4'b0011, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1111, 4'b0010, 32'd4, 32'd3, 32'd2, 32'd1, 4'b0000, 4'b0011, 4'b0000, 1'b0};

        rst_n = 1'b0;
        start = 4'b0000; clear = 4'b0000; en = 4'b0000; mode = 4'b0000;
        period = 128'd0;
        start4 = 1'b0; clear4 = 1'b0; en4 = 1'b0; mode4 = 1'b0; period4 = 4'd0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset state.
        chk("reset_count", count[31:0] | count[63:32] | count[95:64] | count[127:96], 32'd0);
        chk("reset_tc",    {28'd0, tc},   32'd0);
        chk("reset_busy",  {28'd0, busy}, 32'd0);
        chk("reset_done",  {28'd0, done}, 32'd0);
        chk("reset_any",   {31'd0, any_tc}, 32'd0);

        // Table-driven vectors.
        for (int r = 0; r < 11; r++) begin
            start = tbl[r].start; clear = tbl[r].clear;
            en = tbl[r].en; mode = tbl[r].mode;
            period = {32'd0, 32'd0, tbl[r].p1, tbl[r].p0};
            step();
            chk($sformatf("row%0d_c0", r),   cnt(0), tbl[r].c0);
            chk($sformatf("row%0d_c1", r),   cnt(1), tbl[r].c1);
            chk($sformatf("row%0d_tc", r),   {28'd0, tc},   {28'd0, tbl[r].tc});
            chk($sformatf("row%0d_busy", r), {28'd0, busy}, {28'd0, tbl[r].busy});
            chk($sformatf("row%0d_done", r), {28'd0, done}, {28'd0, tbl[r].done});
            chk($sformatf("row%0d_any", r),  {31'd0, any_tc}, {31'd0, tbl[r].any});
        end
        start = 4'b0000;
        m0 = 2;

        // ch2 periodic period 5 with a 3-cycle pause at count 2.
        period[95:64] = 32'd5; mode[2] = 1'b0; start[2] = 1'b1;
        step(); m0 = (m0 + 1) % 4;
        start[2] = 1'b0;
        chk("p_start_c2", cnt(2), 32'd0);
        chk("p_start_c0", cnt(0), m0);
        step(); m0 = (m0 + 1) % 4;
        step(); m0 = (m0 + 1) % 4;
        chk("p_pre_c2", cnt(2), 32'd2);
        en[2] = 1'b0;
        period[95:64] = 32'd9;   // must not take effect until next start
        for (int k = 0; k < 3; k++) begin
            step(); m0 = (m0 + 1) % 4;
            chk($sformatf("p_hold%0d_c2", k), cnt(2), 32'd2);
            chk($sformatf("p_hold%0d_tc2", k), {31'd0, tc[2]}, 32'd0);
            chk($sformatf("p_hold%0d_c0", k), cnt(0), m0);
        end
        en[2] = 1'b1;
        step(); m0 = (m0 + 1) % 4;
        chk("p_run3_c2", cnt(2), 32'd3);
        step(); m0 = (m0 + 1) % 4;
        chk("p_run4_c2", cnt(2), 32'd4);
        chk("p_run4_tc2", {31'd0, tc[2]}, 32'd0);
        step(); m0 = (m0 + 1) % 4;
        chk("p_wrap_c2", cnt(2), 32'd0);
        chk("p_wrap_tc2", {31'd0, tc[2]}, 32'd1);
        chk("p_wrap_any", {31'd0, any_tc}, 32'd1);
        chk("p_wrap_c0", cnt(0), m0);
        step();
        chk("p_after_c2", cnt(2), 32'd1);
        chk("p_after_tc2", {31'd0, tc[2]}, 32'd0);

        // ch3 period 1 periodic: tc every cycle, count stuck at 0.
        period[127:96] = 32'd1; mode[3] = 1'b0; en[3] = 1'b1; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        chk("p1_start_tc3", {31'd0, tc[3]}, 32'd0);
        chk("p1_start_busy3", {31'd0, busy[3]}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("p1_c3_%0d", k), cnt(3), 32'd0);
            chk($sformatf("p1_tc3_%0d", k), {31'd0, tc[3]}, 32'd1);
        end

        // Simultaneous clear and start on ch3 during RUN: clear wins.
        clear[3] = 1'b1; start[3] = 1'b1;
        step();
        clear[3] = 1'b0; start[3] = 1'b0;
        chk("cs_busy3", {31'd0, busy[3]}, 32'd0);
        chk("cs_c3", cnt(3), 32'd0);
        chk("cs_tc3", {31'd0, tc[3]}, 32'd0);
        step();
        chk("cs_idle_busy3", {31'd0, busy[3]}, 32'd0);
        chk("cs_idle_c3", cnt(3), 32'd0);

        // Restart during RUN at count 7 with a new period of 3.
        period[127:96] = 32'd20; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        repeat (7) step();
        chk("rs_c3_7", cnt(3), 32'd7);
        period[127:96] = 32'd3; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        chk("rs_c3_0", cnt(3), 32'd0);
        chk("rs_busy3", {31'd0, busy[3]}, 32'd1);
        step(); step();
        chk("rs_c3_2", cnt(3), 32'd2);
        step();
        chk("rs_wrap_c3", cnt(3), 32'd0);
        chk("rs_wrap_tc3", {31'd0, tc[3]}, 32'd1);

        // WIDTH=4 instance, period 0: wraps after 16 counts.
        period4 = 4'd0; en4 = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("w4_start", {28'd0, count4}, 32'd0);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("w4_c%0d", k), {28'd0, count4}, k);
            chk($sformatf("w4_tc%0d", k), {31'd0, tc4}, 32'd0);
        end
        step();
        chk("w4_wrap_c", {28'd0, count4}, 32'd0);
        chk("w4_wrap_tc", {31'd0, tc4}, 32'd1);
        chk("w4_wrap_any", {31'd0, any_tc4}, 32'd1);

        // Asynchronous reset between edges mid-count.
        en = 4'b1111;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count_lo", count[31:0] | count[63:32], 32'd0);
        chk("ar_count_hi", count[95:64] | count[127:96], 32'd0);
        chk("ar_status", {16'd0, tc, busy, done, 3'd0, any_tc}, 32'd0);
        chk("ar_w4", {24'd0, count4, 3'd0, busy4}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("ar_idle_busy", {28'd0, busy}, 32'd0);
        chk("ar_idle_count", count[31:0] | count[63:32] | count[95:64] | count[127:96], 32'd0);
        chk("ar_idle_tc", {28'd0, tc}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor to the single free-running period counter: CHANNELS independent counters, each WIDTH bits, with a per-channel period latched at start.
- Each channel runs in one of two modes: periodic (wrap) or one-shot (run once, then hold).
- Adds enable/pause, restart, synchronous clear, a terminal-count pulse, and busy/done status per channel.
- Timing backbone for the simulator: frame/line timers and periodic event strobes to other blocks.

Parameters:
- WIDTH, 32, bit width of each channel's counter and period.
- CHANNELS, 4, number of independent channels (>=1).

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  CHANNELS  per-channel start/restart strobe.
- clear_in  input  CHANNELS  per-channel synchronous clear.
- en_in  input  CHANNELS  per-channel count enable; low pauses the channel.
- mode_in  input  CHANNELS  0 = periodic, 1 = one-shot; latched on start.
- period_in  input  CHANNELS*WIDTH  channel i uses bits [i*WIDTH +: WIDTH]; latched on start.
- count_out  output  CHANNELS*WIDTH  current count per channel, same packing as period_in.
- tc_out  output  CHANNELS  one-cycle terminal-count pulse per channel.
- busy_out  output  CHANNELS  channel in RUN.
- done_out  output  CHANNELS  channel in DONE (one-shot finished).
- any_tc_out  output  1  registered OR of the per-channel terminal-count events.

Behaviour:
- Reset: while rst_n_in = 0, asynchronously for all channels: state = IDLE, count_out = 0, tc_out = 0, busy_out = 0, done_out = 0, any_tc_out = 0, latched period and mode = 0.
- Per-channel FSM states: IDLE, RUN, DONE.
- Channels are fully independent; only any_tc_out combines them.
- Per-channel priority each cycle: clear_in > start_in > count.
- clear_in = 1: next cycle state = IDLE, count = 0, tc = 0. Latched period/mode keep their values.
- start_in = 1 (any state, including RUN): on the next cycle:
  - latch period_in slice and mode_in bit;
  - count = 0, state = RUN, tc = 0;
  - en_in is ignored that cycle.
- Effective terminal value T = latched period - 1, computed modulo 2^WIDTH.
  - period = 0 gives T = all-ones, i.e. a full 2^WIDTH range.
  - period = 1 gives T = 0: periodic mode pulses tc every enabled cycle.
- RUN with en_in = 1 and count != T: count increments by 1, no tc.
- RUN with en_in = 1 and count == T:
  - periodic: count -> 0, stay in RUN, tc = 1 on the next cycle.
  - one-shot: count holds at T, state -> DONE, tc = 1 on the next cycle.
- RUN with en_in = 0: count holds, tc = 0, state unchanged. Pausing on count == T delays the tc event until enable returns.
- IDLE/DONE: count holds, tc = 0. en_in has no effect; only start or clear leave these states.
- tc_out is registered. It is high exactly one cycle, in the same cycle count_out first shows 0 (periodic) or the first DONE cycle (one-shot).
- busy_out = (state == RUN); done_out = (state == DONE). Both registered with the state.
- any_tc_out asserts in the same cycle as any tc_out bit, one cycle high per event cycle.
- Latency: start strobe at edge N gives count 0 after edge N, 1 after edge N+1 (with enable high). The first periodic tc arrives period cycles after the start edge.
- Changing period_in or mode_in while in RUN has no effect until the next start.
- Reset asserted mid-run: immediate return to the reset values; no tc is generated.

Test Plan:
- Reset, then ch0 start with period = 4, periodic, en = 1 held: count 0,1,2,3,0,1…; tc_out[0] high in each cycle count returns to 0; any_tc_out matches; busy_out[0] = 1.
- ch1 one-shot, period = 3: count 0,1,2 then holds 2; tc_out[1] pulses once; done_out[1] = 1, busy_out[1] = 0; a further start restarts from 0.
- ch2 periodic, period = 5, en_in[2] low for 3 cycles at count = 2: count holds at 2; tc is delayed by exactly 3 cycles; other channels are unaffected.
- Edge periods: period = 1 periodic gives tc every cycle with count stuck at 0. Period = 0 with WIDTH = 4 instance gives a wrap after 16 counts.
- Simultaneous clear_in and start_in on ch3 during RUN: clear wins, giving IDLE, count 0, no tc. Start during RUN at count 7: count 0 the next cycle, new period latched.
- rst_n_in pulsed low asynchronously mid-count (between edges): all outputs go to 0 immediately and stay IDLE after release until a start.
